// File: rtl/cv32e40p_tmr_voter_seq_if.sv
// Vote request/response bundle between triplicated stages, the voter and fault handling.
// Latency: pure wiring, no storage.
// Backpressure: none; the producer presents a vote whenever valid_i is high.
interface cv32e40p_tmr_voter_seq_if #(
    parameter int NBIT  = 32,
    parameter int CNT_W = 4
);
    logic                 valid_i;
    logic [NBIT-1:0]      data1_i;
    logic [NBIT-1:0]      data2_i;
    logic [NBIT-1:0]      data3_i;
    logic                 clear_i;
    logic                 valid_o;
    logic [NBIT-1:0]      dataout_o;
    logic                 error_detected_input_a;
    logic                 error_detected_input_b;
    logic                 error_detected_input_c;
    logic                 error_detected;
    logic                 uncorrectable_o;
    logic [2:0]           faulty_o;
    logic [1:0]           state_o;
    logic [3*CNT_W-1:0]   err_cnt_o;

    modport master (
        output valid_i, data1_i, data2_i, data3_i, clear_i,
        input  valid_o, dataout_o, error_detected_input_a, error_detected_input_b,
               error_detected_input_c, error_detected, uncorrectable_o,
               faulty_o, state_o, err_cnt_o
    );

    modport slave (
        input  valid_i, data1_i, data2_i, data3_i, clear_i,
        output valid_o, dataout_o, error_detected_input_a, error_detected_input_b,
               error_detected_input_c, error_detected, uncorrectable_o,
               faulty_o, state_o, err_cnt_o
    );
endinterface

// File: rtl/cv32e40p_tmr_voter_seq.sv
// Registered bitwise TMR majority voter with per-replica quarantine and DMR/FAIL fallback.
// Latency: 1 cycle valid_i->valid_o; 2 cycles with CV32E40P_VOTER_PIPE_EN defined (input register stage).
// Backpressure: none; every valid vote is accepted and produces exactly one output.
module cv32e40p_tmr_voter_seq #(
    parameter int NBIT   = 32,
    parameter int CNT_W  = 4,
    parameter int THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    cv32e40p_tmr_voter_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_TMR  = 2'b00,
        ST_DEG  = 2'b01,
        ST_FAIL = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

    // Vote stage inputs (either straight from the port or from the input register).
    logic            s_vld;
    logic [NBIT-1:0] d [3];

`ifdef CV32E40P_VOTER_PIPE_EN
    logic            p_vld;
    logic [NBIT-1:0] p_d [3];

    // Input register stage; data only loads on a vote to avoid useless toggling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_vld <= 1'b0;
            for (int i = 0; i < 3; i++) p_d[i] <= '0;
        end else begin
            p_vld <= bus.valid_i;
            if (bus.valid_i) begin
                p_d[0] <= bus.data1_i;
                p_d[1] <= bus.data2_i;
                p_d[2] <= bus.data3_i;
            end
        end
    end

    assign s_vld = p_vld;
    assign d[0]  = p_d[0];
    assign d[1]  = p_d[1];
    assign d[2]  = p_d[2];
`else
    assign s_vld = bus.valid_i;
    assign d[0]  = bus.data1_i;
    assign d[1]  = bus.data2_i;
    assign d[2]  = bus.data3_i;
`endif

    state_t           state_q, state_nxt;
    logic [2:0]       faulty_q;
    logic [CNT_W-1:0] cnt_q   [3];
    logic [CNT_W-1:0] cnt_nxt [3];

    logic [NBIT-1:0]  maj, sel, vote;
    logic [2:0]       mis_maj, mis_sel, flg, inc, hit;
    logic             unc;
    logic [1:0]       n_hit;

    // Vote result, flags and counter/state next values for the current vote.
    always_comb begin
        maj = (d[0] & d[1]) | (d[1] & d[2]) | (d[0] & d[2]);
        // Lowest-index replica still trusted; replica A when every replica is quarantined.
        sel = !faulty_q[0] ? d[0] : !faulty_q[1] ? d[1] : !faulty_q[2] ? d[2] : d[0];
        for (int i = 0; i < 3; i++) begin
            mis_maj[i] = (d[i] != maj);
            mis_sel[i] = (d[i] != sel);
        end

        vote = maj;
        flg  = '0;
        unc  = 1'b0;
        inc  = '0;
        case (state_q)
            ST_TMR: begin
                flg = mis_maj;
                inc = mis_maj;
            end
            ST_DEG: begin
                vote = sel;
                // Two healthy replicas left: any disagreement cannot be attributed.
                if (|(mis_sel & ~faulty_q)) begin
                    flg = ~faulty_q;
                    unc = 1'b1;
                    inc = ~faulty_q;
                end
            end
            ST_FAIL: begin
                vote = sel;
                flg  = mis_sel;
                unc  = 1'b1;
            end
            default: ;
        endcase

        for (int i = 0; i < 3; i++) begin
            cnt_nxt[i] = cnt_q[i];
            hit[i]     = 1'b0;
            if (inc[i] && !faulty_q[i] && (cnt_q[i] != THR)) begin
                cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
                hit[i]     = (cnt_q[i] + CNT_W'(1)) == THR;
            end
        end
        n_hit = {1'b0, hit[0]} + {1'b0, hit[1]} + {1'b0, hit[2]};

        state_nxt = state_q;
        case (state_q)
            ST_TMR: begin
                if (n_hit >= 2'd2)      state_nxt = ST_FAIL;
                else if (n_hit == 2'd1) state_nxt = ST_DEG;
            end
            ST_DEG:  if (|hit) state_nxt = ST_FAIL;
            default: ;
        endcase
    end

    // Health FSM, counters and quarantine mask; clear overrides any same-cycle vote update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_TMR;
            faulty_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else if (bus.clear_i) begin
            state_q  <= ST_TMR;
            faulty_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else if (s_vld) begin
            state_q  <= state_nxt;
            faulty_q <= faulty_q | hit;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_nxt[i];
        end
    end

    logic            valid_q, unc_q, err_q;
    logic [NBIT-1:0] dout_q;
    logic [2:0]      flg_q;

    // Output register: data holds between votes, flags only live alongside valid_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            dout_q  <= '0;
            flg_q   <= '0;
            err_q   <= 1'b0;
            unc_q   <= 1'b0;
        end else begin
            valid_q <= s_vld;
            if (s_vld) begin
                dout_q <= vote;
                flg_q  <= flg;
                err_q  <= |flg;
                unc_q  <= unc;
            end else begin
                flg_q  <= '0;
                err_q  <= 1'b0;
                unc_q  <= 1'b0;
            end
        end
    end

    assign bus.valid_o                = valid_q;
    assign bus.dataout_o              = dout_q;
    assign bus.error_detected_input_a = flg_q[0];
    assign bus.error_detected_input_b = flg_q[1];
    assign bus.error_detected_input_c = flg_q[2];
    assign bus.error_detected         = err_q;
    assign bus.uncorrectable_o        = unc_q;
    assign bus.faulty_o               = faulty_q;
    assign bus.state_o                = state_q;
    assign bus.err_cnt_o              = {cnt_q[2], cnt_q[1], cnt_q[0]};

endmodule

// File: tb/tb_cv32e40p_tmr_voter_seq.sv
// Scoreboard bench for the sequential TMR voter: expected results queued at drive time, checked on valid_o.
// Latency: follows CV32E40P_VOTER_PIPE_EN (1 or 2 cycles).
// Backpressure: none exercised; the DUT has no ready.
module tb_cv32e40p_tmr_voter_seq;
    localparam int NBIT = 32, CNT_W = 4, THRESH = 4;
`ifdef CV32E40P_VOTER_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cv32e40p_tmr_voter_seq_if #(.NBIT(NBIT), .CNT_W(CNT_W)) bus ();

    cv32e40p_tmr_voter_seq #(.NBIT(NBIT), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] dat;
        logic [2:0]  flg;   // {c,b,a}
        logic        err;
        logic        unc;
        logic [2:0]  fty;
        logic [1:0]  st;
        logic [11:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic exp_t mk(input logic [31:0] dat, input logic [2:0] flg, input logic unc,
                                input logic [2:0] fty, input logic [1:0] st, input logic [11:0] cnt);
        mk = {dat, flg, |flg, unc, fty, st, cnt};
    endfunction

    // Scoreboard: every valid output is matched against the oldest queued expectation.
    exp_t mon_e, mon_o;
    always @(negedge clk) begin
        if (!rst && bus.valid_o === 1'b1) begin
            mon_o = {bus.dataout_o,
                     {bus.error_detected_input_c, bus.error_detected_input_b, bus.error_detected_input_a},
                     bus.error_detected, bus.uncorrectable_o, bus.faulty_o, bus.state_o, bus.err_cnt_o};
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_output got dat=%h flg=%b", mon_o.dat, mon_o.flg);
            end else begin
                mon_e = q.pop_front();
                if (mon_o !== mon_e) begin
                    n_fail++;
                    $display("FAIL sb_vote got dat=%h flg=%b err=%b unc=%b fty=%b st=%b cnt=%h exp dat=%h flg=%b err=%b unc=%b fty=%b st=%b cnt=%h",
                             mon_o.dat, mon_o.flg, mon_o.err, mon_o.unc, mon_o.fty, mon_o.st, mon_o.cnt,
                             mon_e.dat, mon_e.flg, mon_e.err, mon_e.unc, mon_e.fty, mon_e.st, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        repeat (n) step();
    endtask

    task automatic vote(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic clr, input exp_t e);
        bus.valid_i = 1'b1;
        bus.data1_i = a;
        bus.data2_i = b;
        bus.data3_i = c;
        q.push_back(e);
`ifdef CV32E40P_VOTER_PIPE_EN
        bus.clear_i = 1'b0;
        step();
        bus.valid_i = 1'b0;
        // Clear must meet the vote while it sits in the voting stage.
        if (clr) begin
            bus.clear_i = 1'b1;
            step();
            bus.clear_i = 1'b0;
        end
`else
        bus.clear_i = clr;
        step();
        bus.valid_i = 1'b0;
        bus.clear_i = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) begin
            bus.valid_i = 1'b1;
            bus.clear_i = 1'($urandom_range(0, 1));
            bus.data1_i = $urandom;
            bus.data2_i = $urandom;
            bus.data3_i = $urandom;
            @(negedge clk);
            n_tests++;
            if ({bus.valid_o, bus.dataout_o, bus.error_detected_input_a, bus.error_detected_input_b,
                 bus.error_detected_input_c, bus.error_detected, bus.uncorrectable_o,
                 bus.faulty_o, bus.state_o, bus.err_cnt_o} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs got valid=%b dat=%h st=%b cnt=%h fty=%b required all 0",
                         bus.valid_o, bus.dataout_o, bus.state_o, bus.err_cnt_o, bus.faulty_o);
            end
            step();
        end
        bus.valid_i = 1'b0;
        bus.clear_i = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (bus.valid_o !== 1'b0 || bus.state_o !== 2'b00 || bus.err_cnt_o !== 12'h000 ||
                bus.faulty_o !== 3'b000) begin
                n_fail++;
                $display("FAIL post_reset_idle got valid=%b st=%b cnt=%h fty=%b required 0",
                         bus.valid_o, bus.state_o, bus.err_cnt_o, bus.faulty_o);
            end
            step();
        end
    endtask

    task automatic test_tmr_single();
        vote(32'h0000_0001, 32'h0, 32'h0, 1'b0, mk(32'h0, 3'b001, 1'b0, 3'b000, 2'b00, 12'h001));
    endtask

    task automatic test_bitwise();
        vote(32'hFF00_0000, 32'h00FF_0000, 32'hF0F0_0000, 1'b0,
             mk(32'hF0F0_0000, 3'b011, 1'b0, 3'b000, 2'b00, 12'h012));
    endtask

    task automatic test_clear_idle();
        idle(LAT + 1);
        bus.clear_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.err_cnt_o !== 12'h000 || bus.state_o !== 2'b00 || bus.faulty_o !== 3'b000) begin
            n_fail++;
            $display("FAIL clear_idle got cnt=%h st=%b fty=%b required 0", bus.err_cnt_o, bus.state_o, bus.faulty_o);
        end
        step();
    endtask

    task automatic test_degrade();
        for (int k = 1; k <= 4; k++)
            vote(32'h5, 32'h7, 32'h5, 1'b0,
                 mk(32'h5, 3'b010, 1'b0, (k == 4) ? 3'b010 : 3'b000, (k == 4) ? 2'b01 : 2'b00, 12'(k << 4)));
        vote(32'h5, 32'h0, 32'h6, 1'b0, mk(32'h5, 3'b101, 1'b1, 3'b010, 2'b01, 12'h141));
    endtask

    task automatic test_fail_and_clear();
        for (int k = 2; k <= 4; k++)
            vote(32'h5, 32'h0, 32'h6, 1'b0,
                 mk(32'h5, 3'b101, 1'b1, (k == 4) ? 3'b111 : 3'b010, (k == 4) ? 2'b10 : 2'b01,
                    12'((k << 8) | (4 << 4) | k)));
        vote(32'h8, 32'h9, 32'h9, 1'b0, mk(32'h8, 3'b110, 1'b1, 3'b111, 2'b10, 12'h444));
        vote(32'h11, 32'h22, 32'h33, 1'b1, mk(32'h11, 3'b110, 1'b1, 3'b000, 2'b00, 12'h000));
        idle(LAT + 1);
        @(negedge clk);
        n_tests++;
        if (bus.err_cnt_o !== 12'h000 || bus.state_o !== 2'b00 || bus.faulty_o !== 3'b000) begin
            n_fail++;
            $display("FAIL clear_with_vote got cnt=%h st=%b fty=%b required 0", bus.err_cnt_o, bus.state_o, bus.faulty_o);
        end
        step();
    endtask

    task automatic test_idle_hold();
        vote(32'hABCD_0001, 32'hABCD_0000, 32'hABCD_0000, 1'b0,
             mk(32'hABCD_0000, 3'b001, 1'b0, 3'b000, 2'b00, 12'h001));
        idle(LAT);
        for (int i = 0; i < 10; i++) begin
            bus.valid_i = 1'b0;
            bus.data1_i = $urandom;
            bus.data2_i = $urandom;
            bus.data3_i = $urandom;
            @(negedge clk);
            n_tests++;
            if (bus.valid_o !== 1'b0 || bus.dataout_o !== 32'hABCD_0000 || bus.error_detected !== 1'b0 ||
                bus.state_o !== 2'b00 || bus.err_cnt_o !== 12'h001) begin
                n_fail++;
                $display("FAIL idle_hold cyc %0d got valid=%b dat=%h err=%b st=%b cnt=%h required 0 abcd0000 0 00 001",
                         i, bus.valid_o, bus.dataout_o, bus.error_detected, bus.state_o, bus.err_cnt_o);
            end
            step();
        end
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.clear_i = 1'b0;
        bus.data1_i = '0;
        bus.data2_i = '0;
        bus.data3_i = '0;
        test_reset();
        test_tmr_single();
        test_bitwise();
        test_clear_idle();
        test_degrade();
        test_fail_and_clear();
        test_idle_hold();
        idle(LAT + 2);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d outstanding required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
